// File: rtl/lsu_req_issue_pkg.sv
// Shared definitions for the LSU request-issue slice.
//   - exc_cause_e : exception cause encoding {store, crossborder}
//   - F3_*        : load/store width/sign codes carried in func3
//   - MAX_OUTST_DEF : default bound on loads in flight (data-buffer FIFO depth)
//   - reg_mask()  : one-hot register mask helper, x0 never marked
package lsu_req_issue_pkg;

    localparam int MAX_OUTST_DEF = 4;

    typedef enum logic [1:0] {
        EXC_LD_MISALIGN = 2'b00,
        EXC_LD_RANGE    = 2'b01,
        EXC_ST_MISALIGN = 2'b10,
        EXC_ST_RANGE    = 2'b11
    } exc_cause_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [31:0] reg_mask(input logic [4:0] idx, input logic en);
        logic [31:0] m;
        m = '0;
        if (en && (idx != 5'd0)) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lsu_scoreboard.sv
// Per-register pending-load scoreboard.
//   set_mask / clr_mask : registers to mark / release at the next edge (set wins)
//   rs1, rs2, rd        : lookup indices
//   pend_rs1/2, pend_rd : registered pending state of the looked-up registers
// Bit 0 is forced clear so x0 never reads as pending.
module lsu_scoreboard
    import lsu_req_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] set_mask,
    input  logic [31:0] clr_mask,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    output logic        pend_rs1,
    output logic        pend_rs2,
    output logic        pend_rd
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    always_comb begin
        pending_d = ((pending_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_rs1 = pending_q[rs1];
    assign pend_rs2 = pending_q[rs2];
    assign pend_rd  = pending_q[rd];

endmodule

// File: rtl/lsu_req_issue.sv
// Load/store request issue toward the data buffer.
// Holds one EX op in a request slot until the data buffer enqueues it (or
// flags it as an address error), counts loads in flight, keeps a pending
// scoreboard per destination register, registers load returns for writeback
// and pulses an exception on an errored slot.
// Ports:
//   EX side   : ex_valid/ex_load/ex_store/ex_func3/ex_rd/ex_addr/ex_wdata, ex_ready
//   ID side   : rs1, rs2 -> hazard (and byp1_en/byp2_en when bypass is built)
//   Buffer    : func3, rd, in_top_address, data_to_mem, in_top_load, in_top_store,
//               full, er_load_n/er_load_c/er_store_n/er_store_c
//   Return    : out_wr_reg, out_rd, o_rd_final_data -> wb_en, wb_rd, wb_data
//   Exception : exc_valid, exc_cause, exc_addr
// Build option LSU_WB_BYPASS_EN: a source matching the register being written
// back this cycle is not a hazard; byp1_en/byp2_en select wb_data instead.
module lsu_req_issue
    import lsu_req_issue_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [2:0]  ex_func3,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        ex_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
`ifdef LSU_WB_BYPASS_EN
    output logic        byp1_en,
    output logic        byp2_en,
`endif
    output logic [2:0]  func3,
    output logic [4:0]  rd,
    output logic [31:0] in_top_address,
    output logic [31:0] data_to_mem,
    output logic        in_top_load,
    output logic        in_top_store,
    input  logic        full,
    input  logic        er_load_n,
    input  logic        er_load_c,
    input  logic        er_store_n,
    input  logic        er_store_c,
    input  logic        out_wr_reg,
    input  logic [4:0]  out_rd,
    input  logic [31:0] o_rd_final_data,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int SUM_W = CNT_W + 1;

    logic             slot_v_q, slot_v_d;
    logic             slot_load_q, slot_load_d;
    logic             slot_store_q, slot_store_d;
    logic [2:0]       slot_func3_q, slot_func3_d;
    logic [4:0]       slot_rd_q, slot_rd_d;
    logic [31:0]      slot_addr_q, slot_addr_d;
    logic [31:0]      slot_wdata_q, slot_wdata_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             exc_valid_q, exc_valid_d;
    logic [1:0]       exc_cause_q, exc_cause_d;
    logic [31:0]      exc_addr_q, exc_addr_d;

    logic             err, retire, enqueue, accept, block;
    logic             slot_load_pend, ld_enq, ret_ok;
    logic [SUM_W-1:0] outst_sum;
    logic             pend_rs1, pend_rs2, pend_rd;
    logic [31:0]      set_mask, clr_mask;

    assign err     = er_load_n | er_load_c | er_store_n | er_store_c;
    assign retire  = slot_v_q & (~full | err);
    assign enqueue = slot_v_q & ~full & ~err;
    assign ld_enq  = enqueue & slot_load_q;

    // A slot load that is not erroring is already committed to the buffer,
    // so it counts toward the in-flight bound alongside the registered count.
    assign slot_load_pend = slot_v_q & slot_load_q & ~err;
    assign outst_sum      = {1'b0, outst_q} + {{CNT_W{1'b0}}, slot_load_pend};
    assign block          = ex_load & (pend_rd | (outst_sum >= SUM_W'(MAX_OUTST)));
    assign ex_ready       = (~slot_v_q | retire) & ~block;
    assign accept         = ex_valid & ex_ready;

    // Returns with nothing in flight are stale (e.g. arriving after a reset).
    assign ret_ok = out_wr_reg & (outst_q != '0);

    assign set_mask = reg_mask(ex_rd, accept & ex_load);
    assign clr_mask = reg_mask(wb_rd_q, wb_en_q)
                    | reg_mask(slot_rd_q, slot_v_q & err & slot_load_q);

    lsu_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (ex_rd),
        .pend_rs1 (pend_rs1),
        .pend_rs2 (pend_rs2),
        .pend_rd  (pend_rd)
    );

`ifdef LSU_WB_BYPASS_EN
    assign byp1_en = wb_en_q & (rs1 == wb_rd_q) & (rs1 != 5'd0);
    assign byp2_en = wb_en_q & (rs2 == wb_rd_q) & (rs2 != 5'd0);
    assign hazard  = (pend_rs1 & ~byp1_en) | (pend_rs2 & ~byp2_en);
`else
    assign hazard  = pend_rs1 | pend_rs2;
`endif

    always_comb begin
        slot_v_d     = slot_v_q;
        slot_load_d  = slot_load_q;
        slot_store_d = slot_store_q;
        slot_func3_d = slot_func3_q;
        slot_rd_d    = slot_rd_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        if (accept) begin
            slot_v_d     = 1'b1;
            slot_load_d  = ex_load;
            slot_store_d = ex_store;
            slot_func3_d = ex_func3;
            slot_rd_d    = ex_rd;
            slot_addr_d  = ex_addr;
            slot_wdata_d = ex_wdata;
        end else if (retire) begin
            slot_v_d = 1'b0;
        end

        outst_d = outst_q;
        if (ld_enq && !ret_ok) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!ld_enq && ret_ok) begin
            outst_d = outst_q - CNT_W'(1);
        end

        wb_en_d   = ret_ok & (out_rd != 5'd0);
        wb_rd_d   = ret_ok ? out_rd : wb_rd_q;
        wb_data_d = ret_ok ? o_rd_final_data : wb_data_q;

        exc_valid_d = slot_v_q & err;
        exc_cause_d = exc_valid_d ? {slot_store_q, er_load_c | er_store_c} : exc_cause_q;
        exc_addr_d  = exc_valid_d ? slot_addr_q : exc_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_v_q     <= 1'b0;
            slot_load_q  <= 1'b0;
            slot_store_q <= 1'b0;
            slot_func3_q <= '0;
            slot_rd_q    <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            outst_q      <= '0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
            exc_addr_q   <= '0;
        end else begin
            slot_v_q     <= slot_v_d;
            slot_load_q  <= slot_load_d;
            slot_store_q <= slot_store_d;
            slot_func3_q <= slot_func3_d;
            slot_rd_q    <= slot_rd_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            outst_q      <= outst_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            exc_valid_q  <= exc_valid_d;
            exc_cause_q  <= exc_cause_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    // The in-flight bound on acceptance must keep the counter from overflowing.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ld_enq && !ret_ok && (outst_q == CNT_W'(MAX_OUTST))));
        end
    end

    assign func3          = slot_func3_q;
    assign rd             = slot_rd_q;
    assign in_top_address = slot_addr_q;
    assign data_to_mem    = slot_wdata_q;
    assign in_top_load    = slot_v_q & slot_load_q;
    assign in_top_store   = slot_v_q & slot_store_q;
    assign wb_en          = wb_en_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign exc_valid      = exc_valid_q;
    assign exc_cause      = exc_cause_q;
    assign exc_addr       = exc_addr_q;

endmodule
